spongent_player_inv: RTL and testbench

SPONGENT_PLAYER_INV -- requirements
Module: spongent_player_inv

---
 rtl/spongent_player_inv.sv | 100 ++++++++++
 tb/tb_spongent_player_inv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spongent_player_inv.sv
// Inverse Spongent pLayer with a byte-serial load/unload interface.
// LOAD collects NSBOX bytes, PERMUTE registers the full b-bit inverse permutation, UNLOAD streams it out.
module spongent_player_inv #(
    parameter int NSBOX = 11,
    parameter int IDXW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic [IDXW-1:0] out_index,
    output logic            busy
);
    localparam int B = 8 * NSBOX;
    localparam logic [IDXW-1:0] LAST = IDXW'(NSBOX - 1);
    localparam logic [IDXW-1:0] ONE  = IDXW'(1);

    typedef enum logic [1:0] {LOAD, PERMUTE, UNLOAD} state_t;

    state_t state, state_nxt;

    logic [NSBOX-1:0][7:0] in_buf;
    logic [NSBOX-1:0][7:0] out_buf;
    logic [IDXW-1:0]       ld_cnt;
    logic [IDXW-1:0]       ul_cnt;
    logic [B-1:0]          in_flat;
    logic [B-1:0]          perm;

    assign in_flat = in_buf;

    // out[j] = in[j*b/4 mod (b-1)]; the top bit is a fixed point.
    for (genvar j = 0; j < B - 1; j++) begin : g_perm
        assign perm[j] = in_flat[(j * (B / 4)) % (B - 1)];
    end
    assign perm[B-1] = in_flat[B-1];

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && ld_cnt == LAST) state_nxt = PERMUTE;
            end
            PERMUTE: begin
                busy      = 1'b1;
                state_nxt = UNLOAD;
            end
            UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && ul_cnt == LAST) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_buf  <= '0;
            out_buf <= '0;
            ld_cnt  <= '0;
            ul_cnt  <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    for (int k = 0; k < NSBOX; k++)
                        if (ld_cnt == IDXW'(k)) in_buf[k] <= in_data;
                    ld_cnt <= (ld_cnt == LAST) ? '0 : ld_cnt + ONE;
                end
                PERMUTE: out_buf <= perm;
                UNLOAD: if (out_ready)
                    ul_cnt <= (ul_cnt == LAST) ? '0 : ul_cnt + ONE;
                default: ;
            endcase
        end
    end

    // Outside UNLOAD the output byte is forced to zero; the index counter is already 0 there.
    always_comb begin
        out_data = 8'h00;
        if (state == UNLOAD)
            for (int k = 0; k < NSBOX; k++)
                if (ul_cnt == IDXW'(k)) out_data = out_buf[k];
    end

    assign out_index = ul_cnt;

endmodule

// File: tb/tb_spongent_player_inv.sv
// Bench for spongent_player_inv: directed vector table, random round trips, back-pressure and reset corners.
module tb_spongent_player_inv;
    localparam int NSBOX = 11;
    localparam int IDXW  = 8;
    localparam int B     = 8 * NSBOX;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      in_data;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [IDXW-1:0] out_index;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    spongent_player_inv #(.NSBOX(NSBOX), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [B-1:0] vin;
        logic [B-1:0] vexp;
    } vec_t;

    // Reference: input bit i lands at output bit (4*i) mod (b-1), top bit fixed.
    function automatic logic [B-1:0] inv_ref(input logic [B-1:0] v);
        logic [B-1:0] o = '0;
        for (int i = 0; i < B - 1; i++) o[(i * 4) % (B - 1)] = v[i];
        o[B-1] = v[B-1];
        return o;
    endfunction

    function automatic logic [B-1:0] fwd_ref(input logic [B-1:0] v);
        logic [B-1:0] o = '0;
        for (int i = 0; i < B - 1; i++) o[(i * (B / 4)) % (B - 1)] = v[i];
        o[B-1] = v[B-1];
        return o;
    endfunction

    function automatic logic [B-1:0] rand_state();
        logic [95:0] t = {$urandom(), $urandom(), $urandom()};
        return t[B-1:0];
    endfunction

    task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers nbytes of v; returns #1 after the edge that accepted the last one.
    task automatic load_vec(input logic [B-1:0] v, input int nbytes, input bit gaps);
        int  k   = 0;
        int  cyc = 0;
        bit  xfer;
        while (k < nbytes && cyc < 500) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = v[8*k +: 8];
            xfer     = in_valid && in_ready;
            tick();
            cyc++;
            if (xfer) k++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (k < nbytes) check("load_timeout", B'(k), B'(nbytes));
    endtask

    task automatic unload_vec(output logic [B-1:0] got, input bit rnd, input int hold_at);
        int  k    = 0;
        int  cyc  = 0;
        bit  held = 0;
        bit  xfer;
        logic [7:0]      hd;
        logic [IDXW-1:0] hi;
        got = '0;
        while (k < NSBOX && cyc < 500) begin
            if (out_valid) check("out_index", B'(out_index), B'(k));
            if (out_valid && k == hold_at && !held) begin
                held      = 1;
                out_ready = 1'b0;
                hd        = out_data;
                hi        = out_index;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    check("hold_data",  B'(out_data),  B'(hd));
                    check("hold_index", B'(out_index), B'(hold_at));
                    check("hold_ready", B'({out_valid, in_ready}), B'(2'b10));
                end
                check("hold_index_entry", B'(hi), B'(hold_at));
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xfer      = out_valid && out_ready;
            if (xfer) got[8*k +: 8] = out_data;
            tick();
            cyc++;
            if (xfer) k++;
        end
        out_ready = 1'b0;
        if (k < NSBOX) check("unload_timeout", B'(k), B'(NSBOX));
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            tick();
            check("rst_outputs", B'({out_valid, out_data, out_index, busy}), '0);
        end
        rst = 1'b0;
        tick();
        check("post_rst", B'({in_ready, out_valid, busy}), B'(3'b100));
    endtask

    vec_t         tbl[4];
    logic [B-1:0] got, r;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        tbl[0].vin = B'(88'h02);                 tbl[0].vexp = B'(88'h10);
        tbl[1].vin = B'(88'h40) << 16;           tbl[1].vexp = B'(88'h02);
        tbl[2].vin = B'(88'h80) << 80;           tbl[2].vexp = B'(88'h80) << 80;
        tbl[3].vin = {B{1'b1}};                  tbl[3].vexp = {B{1'b1}};

        do_reset(2);

        for (int t = 0; t < 4; t++) begin
            load_vec(tbl[t].vin, NSBOX, 1'b0);
            check("latency_permute", B'({out_valid, busy, in_ready}), B'(3'b010));
            tick();
            check("latency_unload", B'({out_valid, busy}), B'(2'b11));
            unload_vec(got, 1'b0, -1);
            check($sformatf("table_%0d", t), got, tbl[t].vexp);
            check("b2b_ready", B'({in_ready, busy}), B'(2'b10));
        end

        // back-pressure at index 5
        r = rand_state();
        load_vec(r, NSBOX, 1'b1);
        unload_vec(got, 1'b0, 5);
        check("backpressure", got, inv_ref(r));

        for (int n = 0; n < 100; n++) begin
            r = rand_state();
            load_vec(fwd_ref(r), NSBOX, 1'b1);
            unload_vec(got, 1'b1, -1);
            check("round_trip", got, r);
        end

        // reset after 6 loaded bytes
        load_vec({B{1'b1}}, 6, 1'b0);
        do_reset(2);
        r = rand_state();
        load_vec(r, NSBOX, 1'b0);
        unload_vec(got, 1'b0, -1);
        check("rst_mid_load", got, inv_ref(r));

        // reset during PERMUTE
        load_vec({B{1'b1}}, NSBOX, 1'b0);
        do_reset(1);
        r = rand_state();
        load_vec(r, NSBOX, 1'b0);
        unload_vec(got, 1'b1, -1);
        check("rst_mid_permute", got, inv_ref(r));

        // reset partway through UNLOAD
        load_vec({B{1'b1}}, NSBOX, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        out_ready = 1'b0;
        do_reset(2);
        r = rand_state();
        load_vec(r, NSBOX, 1'b1);
        unload_vec(got, 1'b1, -1);
        check("rst_mid_unload", got, inv_ref(r));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
